gpio_bank: RTL and testbench

- Parametrised GPIO peripheral; successor to the fixed 16-pin GPIO register block on the FemtoRV32 local bus.
- Generalised to N_PINS, with:
  - a configurable-depth input synchroniser;
  - atomic set/clear/toggle output registers;
  - per-pin rising/falling edge capture with a W1C status register and a level interrupt.
- Sits behind device_select. Tristate buffers stay in the top level, driven from pin_out/pin_oe.

---
 rtl/gpio_pkg.sv | 55 +++++
 rtl/gpio_in_sync.sv | 76 +++++++
 rtl/gpio_bank.sv | 144 ++++++++++++++
 tb/tb_gpio_bank.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/gpio_pkg.sv
// Shared definitions for the GPIO bank: register offsets, pin limits and
// the register decode used by the bus front end.
package gpio_pkg;

  localparam int MAX_PINS         = 32;
  localparam int DEBOUNCE_DEFAULT = 1024;

  localparam logic [31:0] OFF_OUT     = 32'h00;
  localparam logic [31:0] OFF_DIR     = 32'h04;
  localparam logic [31:0] OFF_IN      = 32'h08;
  localparam logic [31:0] OFF_SET     = 32'h0C;
  localparam logic [31:0] OFF_CLR     = 32'h10;
  localparam logic [31:0] OFF_TGL     = 32'h14;
  localparam logic [31:0] OFF_RISE_EN = 32'h18;
  localparam logic [31:0] OFF_FALL_EN = 32'h1C;
  localparam logic [31:0] OFF_STATUS  = 32'h20;

  typedef enum logic [3:0] {
    REG_OUT,
    REG_DIR,
    REG_IN,
    REG_SET,
    REG_CLR,
    REG_TGL,
    REG_RISE_EN,
    REG_FALL_EN,
    REG_STATUS,
    REG_NONE
  } reg_sel_e;

  // Byte offset to register; the two low address bits are don't-care.
  function automatic reg_sel_e decode_reg(input logic [31:0] byte_off);
    reg_sel_e r;
    case (byte_off & 32'hFFFF_FFFC)
      OFF_OUT:     r = REG_OUT;
      OFF_DIR:     r = REG_DIR;
      OFF_IN:      r = REG_IN;
      OFF_SET:     r = REG_SET;
      OFF_CLR:     r = REG_CLR;
      OFF_TGL:     r = REG_TGL;
      OFF_RISE_EN: r = REG_RISE_EN;
      OFF_FALL_EN: r = REG_FALL_EN;
      OFF_STATUS:  r = REG_STATUS;
      default:     r = REG_NONE;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] byte_mask(input logic [3:0] wmask);
    logic [31:0] m;
    for (int b = 0; b < 4; b++) m[8*b +: 8] = {8{wmask[b]}};
    return m;
  endfunction

endpackage

// File: rtl/gpio_in_sync.sv
// Per-pin input path: synchroniser, optional debouncer (GPIO_DEBOUNCE_EN),
// previous-value flop and warm-up gated rise/fall detection.
module gpio_in_sync #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 1024
) (
  input  logic clk,
  input  logic reset_n,
  input  logic pin_i,
  input  logic warm_i,
  input  logic rise_en_i,
  input  logic fall_en_i,
  output logic in_o,
  output logic rise_o,
  output logic fall_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s_val;
  logic                   in_val;
  logic                   prev_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) sync_q <= '0;
    else          sync_q <= {sync_q[SYNC_STAGES-2:0], pin_i};
  end

  assign s_val = sync_q[SYNC_STAGES-1];

`ifdef GPIO_DEBOUNCE_EN
  localparam int               CNT_W    = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             db_q, db_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // During warm-up the debounced value tracks the synchroniser directly so a
  // pin already high at reset does not look like a rise once detection opens.
  always_comb begin
    db_d  = db_q;
    cnt_d = CNT_LOAD;
    if (!warm_i) begin
      db_d = s_val;
    end else if (s_val != db_q) begin
      if (cnt_q == '0) db_d  = s_val;
      else             cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      db_q  <= 1'b0;
      cnt_q <= '0;
    end else begin
      db_q  <= db_d;
      cnt_q <= cnt_d;
    end
  end

  assign in_val = db_q;
`else
  localparam int unused_debounce_cycles = DEBOUNCE_CYCLES;

  assign in_val = s_val;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) prev_q <= 1'b0;
    else          prev_q <= warm_i ? in_val : s_val;
  end

  assign in_o   = in_val;
  assign rise_o = warm_i &  in_val & ~prev_q & rise_en_i;
  assign fall_o = warm_i & ~in_val &  prev_q & fall_en_i;

endmodule

// File: rtl/gpio_bank.sv
// Parametrised GPIO bank on the local bus: OUT/DIR/IN, atomic set/clear/toggle,
// edge capture with W1C status and level irq. Debounce via GPIO_DEBOUNCE_EN.
module gpio_bank
  import gpio_pkg::*;
#(
  parameter int N_PINS          = 16,
  parameter int SYNC_STAGES     = 2,
  parameter int ADDR_W          = 6,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              sel,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  input  logic [3:0]        wmask,
  input  logic              rstrb,
  output logic [31:0]       rdata,
  output logic              rvalid,
  input  logic [N_PINS-1:0] pin_in,
  output logic [N_PINS-1:0] pin_out,
  output logic [N_PINS-1:0] pin_oe,
  output logic              irq
);

  if (N_PINS < 1 || N_PINS > MAX_PINS) begin : g_bad_n_pins
    $error("gpio_bank: N_PINS out of range");
  end
  if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync
    $error("gpio_bank: SYNC_STAGES out of range");
  end

  localparam int               WARM_W    = $clog2(SYNC_STAGES + 2);
  localparam logic [WARM_W-1:0] WARM_DONE = WARM_W'(SYNC_STAGES + 1);

  logic [N_PINS-1:0] out_q, out_d;
  logic [N_PINS-1:0] dir_q, dir_d;
  logic [N_PINS-1:0] rise_en_q, rise_en_d;
  logic [N_PINS-1:0] fall_en_q, fall_en_d;
  logic [N_PINS-1:0] status_q, status_d;
  logic [WARM_W-1:0] warm_q, warm_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              rvalid_q, rvalid_d;

  logic [N_PINS-1:0] in_val, rise, fall;
  logic [N_PINS-1:0] keep, wbits, w1c;
  logic [31:0]       bmask, rd_val;
  logic              wr, rd, warm;
  reg_sel_e          rsel;

  assign rsel  = decode_reg(32'(addr));
  assign wr    = sel & (|wmask);
  assign rd    = sel & rstrb;
  assign bmask = byte_mask(wmask);
  assign keep  = bmask[N_PINS-1:0];
  assign wbits = wdata[N_PINS-1:0] & keep;
  assign warm  = (warm_q == WARM_DONE);

  for (genvar i = 0; i < N_PINS; i++) begin : g_pin
    gpio_in_sync #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_in (
      .clk      (clk),
      .reset_n  (reset_n),
      .pin_i    (pin_in[i]),
      .warm_i   (warm),
      .rise_en_i(rise_en_q[i]),
      .fall_en_i(fall_en_q[i]),
      .in_o     (in_val[i]),
      .rise_o   (rise[i]),
      .fall_o   (fall[i])
    );
  end

  always_comb begin
    out_d     = out_q;
    dir_d     = dir_q;
    rise_en_d = rise_en_q;
    fall_en_d = fall_en_q;
    w1c       = '0;
    warm_d    = warm ? warm_q : warm_q + 1'b1;
    if (wr) begin
      case (rsel)
        REG_OUT:     out_d     = (out_q & ~keep) | wbits;
        REG_DIR:     dir_d     = (dir_q & ~keep) | wbits;
        REG_SET:     out_d     = out_q | wbits;
        REG_CLR:     out_d     = out_q & ~wbits;
        REG_TGL:     out_d     = out_q ^ wbits;
        REG_RISE_EN: rise_en_d = (rise_en_q & ~keep) | wbits;
        REG_FALL_EN: fall_en_d = (fall_en_q & ~keep) | wbits;
        REG_STATUS:  w1c       = wbits;
        default:     ;
      endcase
    end
    // A fresh edge in the same cycle as its W1C clear keeps the bit set.
    status_d = (status_q & ~w1c) | rise | fall;
  end

  // Read mux sees pre-write register state.
  always_comb begin
    rd_val = '0;
    case (rsel)
      REG_OUT:     rd_val[N_PINS-1:0] = out_q;
      REG_DIR:     rd_val[N_PINS-1:0] = dir_q;
      REG_IN:      rd_val[N_PINS-1:0] = in_val;
      REG_RISE_EN: rd_val[N_PINS-1:0] = rise_en_q;
      REG_FALL_EN: rd_val[N_PINS-1:0] = fall_en_q;
      REG_STATUS:  rd_val[N_PINS-1:0] = status_q;
      default:     rd_val = '0;
    endcase
    rdata_d  = rd ? rd_val : rdata_q;
    rvalid_d = rd;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_q     <= '0;
      dir_q     <= '0;
      rise_en_q <= '0;
      fall_en_q <= '0;
      status_q  <= '0;
      warm_q    <= '0;
      rdata_q   <= '0;
      rvalid_q  <= 1'b0;
    end else begin
      out_q     <= out_d;
      dir_q     <= dir_d;
      rise_en_q <= rise_en_d;
      fall_en_q <= fall_en_d;
      status_q  <= status_d;
      warm_q    <= warm_d;
      rdata_q   <= rdata_d;
      rvalid_q  <= rvalid_d;
    end
  end

  assign rdata   = rdata_q;
  assign rvalid  = rvalid_q;
  assign pin_out = out_q;
  assign pin_oe  = dir_q;
  assign irq     = |status_q;

endmodule

// File: tb/tb_gpio_bank.sv
// Self-checking bench for gpio_bank: directed register-map checks plus
// randomized bus/pin traffic against a queue-based behavioural model.
module tb_gpio_bank;

  localparam int          NP    = 16;
  localparam int          S     = 2;
  localparam logic [31:0] PMASK = 32'h0000_FFFF;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          sel = 1'b0;
  logic [5:0]    addr = '0;
  logic [31:0]   wdata = '0;
  logic [3:0]    wmask = '0;
  logic          rstrb = 1'b0;
  logic [31:0]   rdata;
  logic          rvalid;
  logic [NP-1:0] pin_in = '1;
  logic [NP-1:0] pin_out;
  logic [NP-1:0] pin_oe;
  logic          irq;

  int total = 0;
  int bad   = 0;
  bit started = 1'b0;

  gpio_bank #(
    .N_PINS(NP), .SYNC_STAGES(S), .ADDR_W(6), .DEBOUNCE_CYCLES(4)
  ) dut (
    .clk(clk), .reset_n(reset_n), .sel(sel), .addr(addr), .wdata(wdata),
    .wmask(wmask), .rstrb(rstrb), .rdata(rdata), .rvalid(rvalid),
    .pin_in(pin_in), .pin_out(pin_out), .pin_oe(pin_oe), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [31:0] m_out = '0, m_dir = '0, m_rise = '0, m_fall = '0, m_status = '0;
  logic [31:0] m_rdata = '0;
  logic        m_rvalid = 1'b0;
  logic [31:0] hist [0:S];   // hist[0] = newest pin sample
  int          m_edges = 0;

  function automatic logic [31:0] mread(input logic [5:0] a);
    case (a & 6'h3C)
      6'h00:   return m_out;
      6'h04:   return m_dir;
      6'h08:   return hist[S-1];
      6'h18:   return m_rise;
      6'h1C:   return m_fall;
      6'h20:   return m_status;
      default: return 32'h0;
    endcase
  endfunction

  always @(posedge clk or negedge reset_n) begin
    logic [31:0] bm, keep, wb, ev, w1c, s, pv;
    if (!reset_n) begin
      m_out = '0; m_dir = '0; m_rise = '0; m_fall = '0; m_status = '0;
      m_rdata = '0; m_rvalid = 1'b0; m_edges = 0;
      for (int i = 0; i <= S; i++) hist[i] = '0;
    end else begin
      bm = '0;
      for (int b = 0; b < 4; b++) if (wmask[b]) bm[8*b +: 8] = 8'hFF;
      keep = bm & PMASK;
      wb   = wdata & keep;
      s    = hist[S-1];
      pv   = hist[S];
      ev   = '0;
      if (m_edges >= S + 1) ev = ((s & ~pv & m_rise) | (~s & pv & m_fall)) & PMASK;
      if (sel && rstrb) begin
        m_rdata  = mread(addr);
        m_rvalid = 1'b1;
      end else begin
        m_rvalid = 1'b0;
      end
      w1c = '0;
      if (sel && wmask != 0) begin
        case (addr & 6'h3C)
          6'h00: m_out  = (m_out & ~keep) | wb;
          6'h04: m_dir  = (m_dir & ~keep) | wb;
          6'h0C: m_out  = m_out | wb;
          6'h10: m_out  = m_out & ~wb;
          6'h14: m_out  = m_out ^ wb;
          6'h18: m_rise = (m_rise & ~keep) | wb;
          6'h1C: m_fall = (m_fall & ~keep) | wb;
          6'h20: w1c    = wb;
          default: ;
        endcase
      end
      m_status = (m_status & ~w1c) | ev;
      for (int i = S; i > 0; i--) hist[i] = hist[i-1];
      hist[0] = 32'(pin_in);
      if (m_edges < 1000) m_edges++;
    end
  end

  always @(negedge clk) begin
    if (started) begin
      chk("rdata",   rdata,          m_rdata);
      chk("rvalid",  32'(rvalid),    32'(m_rvalid));
      chk("pin_out", 32'(pin_out),   m_out);
      chk("pin_oe",  32'(pin_oe),    m_dir);
      chk("irq",     32'(irq),       32'(m_status != 0));
    end
  end

  // ---------------- bus helpers ----------------
  task automatic bus_wr(input logic [5:0] a, input logic [31:0] d, input logic [3:0] m);
    @(negedge clk);
    sel = 1'b1; addr = a; wdata = d; wmask = m; rstrb = 1'b0;
    @(negedge clk);
    sel = 1'b0; wmask = '0;
  endtask

  task automatic bus_rd(input logic [5:0] a, output logic [31:0] d);
    @(negedge clk);
    sel = 1'b1; addr = a; rstrb = 1'b1; wmask = '0;
    @(negedge clk);
    sel = 1'b0; rstrb = 1'b0;
    d = rdata;
  endtask

  initial begin
    logic [31:0] d;
    int n;

    repeat (3) @(negedge clk);
    started = 1'b1;
    chk("rst_rdata",   rdata,        32'h0);
    chk("rst_rvalid",  32'(rvalid),  32'h0);
    chk("rst_pin_out", 32'(pin_out), 32'h0);
    chk("rst_pin_oe",  32'(pin_oe),  32'h0);
    chk("rst_irq",     32'(irq),     32'h0);

    // Release with pins high and rise detection armed on the very first edge.
    reset_n = 1'b1;
    sel = 1'b1; addr = 6'h18; wdata = 32'hFFFF; wmask = 4'hF;
    @(negedge clk);
    sel = 1'b0; wmask = '0;
    repeat (10) @(negedge clk);
    bus_rd(6'h08, d); chk("in_after_reset", d, 32'hFFFF);
    bus_rd(6'h20, d); chk("status_after_reset", d, 32'h0);
    chk("irq_after_reset", 32'(irq), 32'h0);
    bus_wr(6'h18, 32'h0, 4'hF);

    bus_wr(6'h00, 32'h00F0, 4'hF);
    bus_wr(6'h04, 32'hFFFF, 4'hF);
    bus_wr(6'h0C, 32'h0001, 4'hF);
    bus_wr(6'h10, 32'h0010, 4'hF);
    bus_wr(6'h14, 32'h8000, 4'hF);
    bus_rd(6'h00, d); chk("out_atomic", d, 32'h80E1);
    chk("pin_out_atomic", 32'(pin_out), 32'h80E1);
    chk("pin_oe_all", 32'(pin_oe), 32'hFFFF);

    bus_wr(6'h00, 32'h0, 4'hF);
    bus_wr(6'h00, 32'hAAAA, 4'b0001);
    bus_rd(6'h00, d); chk("out_bytelane", d, 32'h00AA);

    bus_wr(6'h18, 32'h0004, 4'hF);
    @(negedge clk) pin_in = 16'hFFFB;
    repeat (6) @(negedge clk);
    bus_rd(6'h20, d); chk("status_no_fall", d, 32'h0);
    @(negedge clk) pin_in = 16'hFFFF;
    n = 0;
    while (n < S + 2 && !irq) begin
      @(negedge clk);
      n++;
    end
    chk("irq_on_rise", 32'(irq), 32'h1);
    bus_rd(6'h20, d); chk("status_rise", d, 32'h0004);
    bus_wr(6'h20, 32'h0004, 4'hF);
    chk("irq_after_w1c", 32'(irq), 32'h0);

    @(negedge clk) pin_in = 16'hFFFB;
    repeat (5) @(negedge clk);
    pin_in = 16'hFFFF;
    repeat (S) @(negedge clk);
    sel = 1'b1; addr = 6'h20; wdata = 32'h0004; wmask = 4'hF;
    @(negedge clk);
    sel = 1'b0; wmask = '0;
    chk("irq_set_wins", 32'(irq), 32'h1);
    bus_rd(6'h20, d); chk("status_set_wins", d, 32'h0004);
    bus_wr(6'h20, 32'h0004, 4'hF);

    bus_rd(6'h00, d); chk("out_before_unmapped", d, 32'h00AA);
    bus_rd(6'h3C, d); chk("unmapped_rdata", d, 32'h0);
    chk("unmapped_rvalid", 32'(rvalid), 32'h1);
    @(negedge clk) chk("rvalid_pulse_end", 32'(rvalid), 32'h0);

    bus_wr(6'h18, 32'h0, 4'hF);
    @(negedge clk);
    sel = 1'b1; addr = 6'h00; rstrb = 1'b1;
    @(posedge clk);
    #1 sel = 1'b0; rstrb = 1'b0;
    chk("midread_rdata", rdata, 32'h00AA);
    reset_n = 1'b0;
    #1;
    chk("midreset_rvalid", 32'(rvalid), 32'h0);
    chk("midreset_rdata",  rdata,       32'h0);
    chk("midreset_pin_out", 32'(pin_out), 32'h0);
    @(negedge clk) reset_n = 1'b1;

    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      if (c == 2000) begin
        #2 reset_n = 1'b0;
        @(negedge clk) reset_n = 1'b1;
      end
      sel   = ($urandom_range(0, 3) != 0);
      addr  = 6'($urandom_range(0, 15) << 2) | 6'($urandom_range(0, 3));
      wdata = $urandom;
      wmask = ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom);
      rstrb = $urandom_range(0, 1) == 1;
      if ($urandom_range(0, 3) == 0) pin_in[$urandom_range(0, NP - 1)] ^= 1'b1;
    end
    @(negedge clk);
    sel = 1'b0; wmask = '0; rstrb = 1'b0;
    repeat (5) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
